// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte strobe in, launch strobe out, plus fill-level and overflow status
interface uart_tx_fifo_if #(parameter int ADDR_W = 4);
  logic [7:0]      in_data;
  logic            in_flag;
  logic            tx_busy;
  logic [7:0]      po_data;
  logic            po_flag;
  logic [ADDR_W:0] fifo_count;
  logic            overflow;
  modport master (output in_data, in_flag, tx_busy, input po_data, po_flag, fifo_count, overflow);
  modport slave  (input in_data, in_flag, tx_busy, output po_data, po_flag, fifo_count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers byte strobes and replays them to uart_tx only while it reports idle
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int START_TIMEOUT = 8
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     tmo;
  logic [7:0]        po_data;
  logic              po_flag, overflow;
  logic              full, push, launch;
  assign full   = count == FULL;
  assign push   = bus.in_flag && !full;
  assign launch = state == IDLE && count != '0 && !bus.tx_busy;
  assign bus.po_data    = po_data;
  assign bus.po_flag    = po_flag;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;
  // storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr] <= bus.in_data;
  // pointers, fill level and the launch/handshake state machine
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tmo      <= '0;
      po_data  <= 8'h00;
      po_flag  <= 1'b0;
      overflow <= 1'b0;
      state    <= IDLE;
    end else begin
      overflow <= bus.in_flag && full;
      po_flag  <= launch;
      count    <= count + CW'(push) - CW'(launch);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE:
          if (launch) begin
            po_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
            tmo     <= '0;
            state   <= WAIT_BUSY;
          end
        WAIT_BUSY:
          if (bus.tx_busy) state <= WAIT_DONE;
          else begin
            tmo <= tmo + 1'b1;
            if (tmo == TW'(START_TIMEOUT - 1)) state <= IDLE;
          end
        WAIT_DONE:
          if (!bus.tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scenarios against a busy-window uart_tx model and a byte-order scoreboard
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  logic sys_clk = 0;
  logic sys_rst_n = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int lc[$];
  int dbl = 0, ovf_cnt = 0, peak = 0, rst_flags = 0;
  bit model_en = 0, pend = 0, prev_flag = 0;
  int lo = 1, hi = 1, cnt = 0;
  uart_tx_fifo_if #(.ADDR_W(4)) bus();
  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .START_TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus.slave));
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  // monitor plus uart_tx model: busy rises one cycle after a launch and lasts lo..hi cycles
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (bus.po_flag) begin
      got.push_back(bus.po_data);
      lc.push_back(cyc);
      if (prev_flag) dbl++;
      if (!sys_rst_n) rst_flags++;
    end
    prev_flag = bus.po_flag;
    if (bus.overflow) ovf_cnt++;
    if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    if (model_en) begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tx_busy = 0;
      end
      if (pend) begin
        bus.tx_busy = 1;
        cnt = $urandom_range(hi, lo);
        pend = 0;
      end
      if (bus.po_flag) pend = 1;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask
  task automatic wait_got(int n, int budget);
    int t = 0;
    while (got.size() < n && t < budget) begin
      tick();
      t++;
    end
  endtask
  task automatic strobe(logic [7:0] b);
    bus.in_data = b;
    bus.in_flag = 1;
    tick();
    bus.in_flag = 0;
  endtask
  task automatic clear();
    got.delete();
    lc.delete();
  endtask
  task automatic test_reset();
    sys_rst_n = 0;
    tick(2);
    checks++; if (bus.fifo_count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    checks++; if (bus.po_flag !== 0) begin errors++; $display("FAIL reset_po_flag got %b want 0", bus.po_flag); end
    checks++; if (bus.po_data !== 8'h00) begin errors++; $display("FAIL reset_po_data got %h want 00", bus.po_data); end
    checks++; if (bus.overflow !== 0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    sys_rst_n = 1;
    tick(2);
  endtask
  task automatic test_single();
    int k;
    lo = 100; hi = 100; pend = 0; cnt = 0; model_en = 1;
    clear();
    k = cyc;
    strobe(8'h2C);
    checks++; if (bus.fifo_count !== 1 || bus.po_flag !== 0) begin errors++; $display("FAIL single_k1 got count=%0d flag=%b want count=1 flag=0", bus.fifo_count, bus.po_flag); end
    tick();
    checks++; if (bus.po_flag !== 1 || bus.po_data !== 8'h2C || bus.fifo_count !== 0) begin errors++; $display("FAIL single_k2 got flag=%b data=%h count=%0d want flag=1 data=2c count=0", bus.po_flag, bus.po_data, bus.fifo_count); end
    tick(110);
    checks++; if (got.size() != 1 || got[0] !== 8'h2C || lc[0] - k != 2) begin errors++; $display("FAIL single_once got %0d launches want exactly 1 of 2c at latency 2", got.size()); end
  endtask
  task automatic test_burst();
    logic [7:0] exp[3] = '{8'h37, 8'hA5, 8'h01};
    lo = 50; hi = 50;
    clear();
    peak = 0;
    for (int i = 0; i < 3; i++) strobe(exp[i]);
    wait_got(3, 400);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL burst_size got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL burst_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    for (int i = 1; i < 3 && i < lc.size(); i++) begin
      checks++; if (lc[i] - lc[i-1] <= 50) begin errors++; $display("FAIL burst_gap%0d got %0d want >50", i, lc[i] - lc[i-1]); end
    end
    checks++; if (peak < 2 || peak > 3) begin errors++; $display("FAIL burst_peak got %0d want 2..3", peak); end
    tick(60);
  endtask
  task automatic test_overflow();
    model_en = 0;
    bus.tx_busy = 1;
    tick(2);
    clear();
    ovf_cnt = 0;
    for (int i = 0; i <= DEPTH; i++) strobe(8'(i));
    tick();
    checks++; if (bus.fifo_count !== DEPTH) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus.fifo_count, DEPTH); end
    checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL ovf_held got %0d launches want 0", got.size()); end
    pend = 0; cnt = 0; lo = 3; hi = 3; model_en = 1;
    bus.tx_busy = 0;
    wait_got(DEPTH, 400);
    tick(40);
    checks++; if (got.size() != DEPTH) begin errors++; $display("FAIL ovf_drain got %0d want %0d", got.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, got[i], 8'(i)); end
    end
  endtask
  task automatic test_wrap();
    logic [7:0] exp[$];
    logic [7:0] b;
    lo = 1; hi = 3;
    clear();
    ovf_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      strobe(b);
      tick(int'($urandom_range(8, 2)));
    end
    wait_got(40, 2000);
    tick(20);
    checks++; if (got.size() != 40) begin errors++; $display("FAIL wrap_size got %0d want 40", got.size()); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL wrap_overflow got %0d want 0", ovf_cnt); end
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask
  task automatic test_timeout();
    int k;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    model_en = 0;
    bus.tx_busy = 0;
    clear();
    k = cyc;
    strobe(a);
    strobe(b);
    wait_got(2, 60);
    checks++; if (got.size() != 2 || got[0] !== a || got[1] !== b) begin errors++; $display("FAIL tmo_order got %0d launches want 2 (%h,%h)", got.size(), a, b); end
    checks++; if (lc.size() != 2 || lc[0] - k != 2 || lc[1] - lc[0] != TMO + 1) begin errors++; $display("FAIL tmo_timing got %0d launches gap %0d want latency 2 gap %0d", lc.size(), lc.size() == 2 ? lc[1] - lc[0] : -1, TMO + 1); end
    tick(TMO + 4);
  endtask
  task automatic test_reset_mid();
    int t = 0;
    pend = 0; cnt = 0; lo = 40; hi = 40; model_en = 1;
    clear();
    for (int i = 0; i < 5; i++) strobe(8'($urandom));
    while (bus.tx_busy !== 1 && t < 20) begin
      tick();
      t++;
    end
    tick();
    checks++; if (bus.tx_busy !== 1) begin errors++; $display("FAIL rstmid_busy got %b want 1", bus.tx_busy); end
    sys_rst_n = 0;
    #1;
    checks++; if (bus.fifo_count !== 0 || bus.po_flag !== 0 || bus.po_data !== 8'h00 || bus.overflow !== 0) begin errors++; $display("FAIL rstmid_async got count=%0d flag=%b data=%h ovf=%b want 0/0/00/0", bus.fifo_count, bus.po_flag, bus.po_data, bus.overflow); end
    tick(3);
    sys_rst_n = 1;
    tick(150);
    checks++; if (got.size() != 1 || rst_flags != 0 || bus.fifo_count !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d launches, %0d in reset, count %0d want 1,0,0", got.size(), rst_flags, bus.fifo_count); end
  endtask
  initial begin
    bus.in_flag = 0;
    bus.in_data = 0;
    bus.tx_busy = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_timeout();
    test_reset_mid();
    checks++; if (dbl != 0) begin errors++; $display("FAIL po_flag_consecutive got %0d want 0", dbl); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer between the rx-side routing logic and a uart_tx instance. It absorbs one-cycle in_flag/in_data byte strobes into a DEPTH-entry FIFO. It replays each byte to uart_tx as a one-cycle po_flag/po_data strobe, and only when the transmitter reports idle through its work_en output. Without this block, bytes that arrive while uart_tx is still shifting are lost.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4 to 256.
ADDR_W, 4, log2(DEPTH); pointer width.
START_TIMEOUT, 8, cycles to wait for tx_busy to rise after a launch before the byte is treated as sent.

Ports:
sys_clk  input  1  system clock, rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
in_data  input  8  byte to enqueue; valid only while in_flag=1.
in_flag  input  1  enqueue strobe; each high cycle is one byte.
tx_busy  input  1  work_en of the downstream uart_tx; 1 = frame in progress.
po_data  output  8  byte presented to uart_tx pi_data.
po_flag  output  1  one-cycle launch pulse to uart_tx pi_flag.
fifo_count  output  ADDR_W+1  entries currently stored, 0..DEPTH.
overflow  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (async, sys_rst_n=0): wr_ptr=rd_ptr=0, fifo_count=0, po_data=8'h00, po_flag=0, overflow=0, state=IDLE, timeout counter=0. Memory contents are don't-care.
- All outputs are registered. No combinational path exists from any input to any output.
- Write: on an edge where in_flag=1 and fifo_count<DEPTH, mem[wr_ptr]<=in_data and wr_ptr increments modulo DEPTH.
  - If fifo_count==DEPTH, the byte is discarded and overflow=1 for exactly that next cycle.
  - Fullness is judged on the pre-edge count. A write on a full FIFO in the same cycle as a pop is still dropped.
- fifo_count: +1 on an accepted write, -1 on a launch, unchanged when both occur in the same cycle. It never exceeds DEPTH and never goes below 0.
- FSM:
  - IDLE: if fifo_count>0 and tx_busy=0, then po_data<=mem[rd_ptr], po_flag<=1, rd_ptr++ (mod DEPTH), timeout counter<=0, and go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: po_flag<=0.
    - If tx_busy=1, go to WAIT_DONE.
    - Otherwise the counter increments; on reaching START_TIMEOUT, go to IDLE (byte counted as sent, no retry).
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- po_flag is high for exactly one cycle per dequeued byte and is never high in two consecutive cycles.
- po_data holds the last launched byte until the next launch.
- Latency: in_flag high in cycle k, empty FIFO, tx idle → po_flag high in cycle k+2 with po_data = that byte.
- Empty FIFO while in_flag=1: the byte is not bypassed; the normal 2-cycle latency applies.
- Back-to-back bytes: the next launch happens no earlier than the first cycle in IDLE after tx_busy has fallen.
- Pointers wrap naturally at DEPTH. Ordering is strict FIFO across the wrap.
- Reset mid-frame: all stored bytes are discarded, state=IDLE, and no po_flag is issued during reset.
- tx_busy=1 while in IDLE (e.g. external activity): the launch is held until tx_busy=0.

Test Plan:
- Single byte: in_flag pulse with in_data=8'h2C, tx_busy=0 → po_flag pulse 2 cycles later with po_data=8'h2C; fifo_count goes 0→1→0; model tx_busy high 1 cycle after po_flag for 100 cycles, and no further po_flag.
- Burst while busy: strobe 8'h37, 8'hA5, 8'h01 on consecutive cycles, with the uart_tx model busy 50 cycles per frame → three po_flag pulses in order 37,A5,01, each launched only after tx_busy falls; peak fifo_count=2 or 3.
- Overflow: hold tx_busy=1 and strobe 17 bytes 0x00..0x10 → fifo_count=16, overflow pulses once on the 17th byte; after release, output order is 0x00..0x0F and 0x10 is never sent.
- Wrap-around: stream 40 bytes with random gaps against the busy model → all 40 bytes emerge in order; the scoreboard shows zero loss and zero duplication.
- Timeout: tx_busy held 0 after a launch → FSM returns to IDLE after START_TIMEOUT=8 cycles and the next queued byte launches on the following cycle.
- Reset mid-operation: 5 bytes queued, assert sys_rst_n=0 for 3 cycles during WAIT_DONE → immediately fifo_count=0 and po_flag=0, po_data=00; after release, no po_flag appears without new input.
